// File: rtl/prio_encoder8to3_seq.sv
// Sequential 8-to-3 priority encoder: captures an active-low request bus
// and emits one index per valid/ready handshake, then pulses done.
module prio_encoder8to3_seq #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_n,
    input  logic       load,
    output logic [2:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       busy,
    output logic       done,
    output logic       none
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       none_q, none_d;

    logic [7:0] req_mask;
    logic [7:0] served_mask;

    function automatic logic [2:0] prio(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        if (LSB_FIRST != 0) begin
            for (int i = 7; i >= 0; i--)
                if (m[i]) idx = 3'(i);
        end else begin
            for (int i = 0; i < 8; i++)
                if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign req_mask    = ~req_n;
    assign served_mask = pending_q & ~(8'd1 << code_q);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        code_d    = code_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        none_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    if (req_mask != 8'd0) begin
                        pending_d = req_mask;
                        code_d    = prio(req_mask);
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = SCAN;
                    end else begin
                        done_d = 1'b1;
                        none_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (valid_q && code_ready) begin
                    pending_d = served_mask;
                    if (served_mask != 8'd0) begin
                        code_d = prio(served_mask);
                    end else begin
                        code_d  = 3'd0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                pending_d = 8'd0;
                code_d    = 3'd0;
                valid_d   = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            none_q    <= none_d;
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign none       = none_q;

endmodule

// File: tb/tb_prio_encoder8to3_seq.sv
// Bench for prio_encoder8to3_seq: LSB-first and MSB-first instances
// driven in lockstep, checked against a hand-written vector table.
module tb_prio_encoder8to3_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_n;
    logic       load;
    logic       code_ready;

    logic [2:0] code_l, code_m;
    logic       valid_l, valid_m;
    logic       busy_l, busy_m;
    logic       done_l, done_m;
    logic       none_l, none_m;

    int errors = 0;
    int checks = 0;

    prio_encoder8to3_seq #(.LSB_FIRST(1)) dut_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_n      (req_n),
        .load       (load),
        .code_out   (code_l),
        .code_valid (valid_l),
        .code_ready (code_ready),
        .busy       (busy_l),
        .done       (done_l),
        .none       (none_l)
    );

    prio_encoder8to3_seq #(.LSB_FIRST(0)) dut_m (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_n      (req_n),
        .load       (load),
        .code_out   (code_m),
        .code_valid (valid_m),
        .code_ready (code_ready),
        .busy       (busy_m),
        .done       (done_m),
        .none       (none_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        msb;
        logic [7:0]  req;
        logic        toggle;
        logic        reload;
        int          n;
        logic [23:0] codes;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string name, input logic msb,
                            input int c, input int v, input int b,
                            input int d, input int nn);
        if (msb) begin
            chk({name, ".code"},  int'(code_m),  c);
            chk({name, ".valid"}, int'(valid_m), v);
            chk({name, ".busy"},  int'(busy_m),  b);
            chk({name, ".done"},  int'(done_m),  d);
            chk({name, ".none"},  int'(none_m),  nn);
        end else begin
            chk({name, ".code"},  int'(code_l),  c);
            chk({name, ".valid"}, int'(valid_l), v);
            chk({name, ".busy"},  int'(busy_l),  b);
            chk({name, ".done"},  int'(done_l),  d);
            chk({name, ".none"},  int'(none_l),  nn);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         k;
        int         cyc;
        logic       rdy;
        logic [2:0] exp_code;
        string      nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        req_n      = v.req;
        load       = 1'b1;
        code_ready = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        req_n = 8'h5A;
        k     = 0;
        cyc   = 0;
        while (k < v.n && cyc < 40) begin
            exp_code = v.codes[3*k +: 3];
            chk_outs($sformatf("%s.c%0d", nm, k), v.msb,
                     int'(exp_code), 1, 1, 0, 0);
            rdy        = v.toggle ? (cyc % 2 == 0) : 1'b1;
            code_ready = rdy;
            if (v.reload && cyc == 2) begin
                load  = 1'b1;
                req_n = 8'hFE;
            end else begin
                load = 1'b0;
            end
            if (rdy) k++;
            cyc++;
            @(negedge clk);
        end
        load       = 1'b0;
        code_ready = 1'b0;
        chk({nm, ".accepts"}, k, v.n);
        chk({nm, ".cycles"}, cyc, v.toggle ? 2 * v.n - 1 : v.n);
        chk_outs({nm, ".done"}, v.msb, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk_outs({nm, ".idle"}, v.msb, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'b11011111, 1'b0, 1'b0, 1,
                    {21'd0, 3'd5}};
        vecs[1] = '{1'b0, 8'b01101011, 1'b0, 1'b0, 3,
                    {15'd0, 3'd7, 3'd4, 3'd2}};
        vecs[2] = '{1'b1, 8'b01101011, 1'b1, 1'b0, 3,
                    {15'd0, 3'd2, 3'd4, 3'd7}};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8,
                    {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 1'b0, 8,
                    {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}};
        vecs[5] = '{1'b1, 8'b01111110, 1'b0, 1'b0, 2,
                    {18'd0, 3'd0, 3'd7}};
        vecs[6] = '{1'b0, 8'b10110111, 1'b1, 1'b0, 2,
                    {18'd0, 3'd6, 3'd3}};

        rst_n      = 1'b0;
        req_n      = 8'hFF;
        load       = 1'b0;
        code_ready = 1'b0;
        #12;
        chk_outs("reset_l", 1'b0, 0, 0, 0, 0, 0);
        chk_outs("reset_m", 1'b1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Empty capture: done and none pulse, nothing else moves.
        @(negedge clk);
        req_n      = 8'hFF;
        load       = 1'b1;
        code_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk_outs("empty_l", 1'b0, 0, 0, 0, 1, 1);
        chk_outs("empty_m", 1'b1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk_outs("empty_after", 1'b0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_outs("empty_after2", 1'b0, 0, 0, 0, 0, 0);

        // Asynchronous reset after two of three codes are accepted.
        req_n      = 8'b01101011;
        load       = 1'b1;
        code_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk_outs("rst_mid.c0", 1'b0, 2, 1, 1, 0, 0);
        @(negedge clk);
        chk_outs("rst_mid.c1", 1'b0, 4, 1, 1, 0, 0);
        @(negedge clk);
        code_ready = 1'b0;
        chk_outs("rst_mid.c2", 1'b0, 7, 1, 1, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rst_mid.async_l", 1'b0, 0, 0, 0, 0, 0);
        chk_outs("rst_mid.async_m", 1'b1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{1'b0, 8'b11111110, 1'b0, 1'b0, 1, 24'd0}, 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
